// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues IMEM requests, presents fetched words to the
// core over valid/ready, and traps misaligned, out-of-window or unanswered fetches.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter int          IMEM_WORDS = 512,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  input  logic        instr_ready,
  input  logic        instrf_update,
  input  logic [31:0] instr,
  output logic        instrfetch,
  output logic [31:0] addr_imem,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_HOLD, S_DISCARD, S_FAULT
  } state_t;

  localparam logic [32:0] LAST_ADDR = {1'b0, IMEM_BASE} + 33'(4 * IMEM_WORDS) - 33'd4;

  state_t      r_state, w_nstate;
  logic [31:0] r_pc, w_pc_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_fetch, r_valid, r_fault, r_busy;
  logic [31:0] r_addr, r_iout, r_ipc;
  logic [1:0]  r_code, w_code_nxt;
  logic        w_misalign, w_oor, w_tmo, w_take, w_cap, w_in_txn;

  assign w_misalign = |r_pc[1:0];
  assign w_oor      = ({1'b0, r_pc} < {1'b0, IMEM_BASE}) || ({1'b0, r_pc} > LAST_ADDR);
  // Counter is 0 in ISSUE, so it equals cycles elapsed since the request went out.
  assign w_tmo      = ({1'b0, r_cnt} + 9'd1) >= 9'(TIMEOUT);
  assign w_take     = r_valid && instr_ready;

  // Next-state
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:    if (run) w_nstate = S_CHECK;
      S_CHECK:   if (pc_load)                 w_nstate = S_CHECK;
                 else if (w_misalign || w_oor) w_nstate = S_FAULT;
                 else                          w_nstate = S_ISSUE;
      S_ISSUE:   w_nstate = pc_load ? S_CHECK : S_WAIT;
      // A redirect landing on the completion cycle has nothing left in flight.
      S_WAIT:    if (pc_load)            w_nstate = instrf_update ? S_CHECK : S_DISCARD;
                 else if (instrf_update) w_nstate = S_HOLD;
                 else if (w_tmo)         w_nstate = S_FAULT;
      S_DISCARD: if (instrf_update)        w_nstate = S_CHECK;
                 else if (!pc_load && w_tmo) w_nstate = S_FAULT;
      S_HOLD:    if (pc_load)     w_nstate = S_CHECK;
                 else if (w_take) w_nstate = run ? S_CHECK : S_IDLE;
      S_FAULT:   if (pc_load) w_nstate = S_CHECK;
      default:   w_nstate = S_IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    w_pc_nxt = r_pc;
    if (pc_load)                       w_pc_nxt = pc_target;
    else if (r_state == S_HOLD && w_take) w_pc_nxt = r_pc + 32'd4;

    w_cnt_nxt = r_cnt;
    if (w_nstate == S_ISSUE)                          w_cnt_nxt = 8'd0;
    else if (r_state inside {S_ISSUE, S_WAIT, S_DISCARD} && r_cnt != 8'hFF)
                                                      w_cnt_nxt = r_cnt + 8'd1;

    w_code_nxt = 2'd0;
    if (w_nstate == S_FAULT) begin
      if (r_state == S_FAULT)      w_code_nxt = r_code;
      else if (r_state == S_CHECK) w_code_nxt = w_misalign ? 2'd1 : 2'd2;
      else                         w_code_nxt = 2'd3;
    end

    w_in_txn = w_nstate inside {S_ISSUE, S_WAIT, S_DISCARD};
    w_cap    = (r_state == S_WAIT) && instrf_update && !pc_load;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= 8'd0;
      r_fetch <= 1'b0;
      r_addr  <= RESET_PC;
      r_valid <= 1'b0;
      r_iout  <= 32'd0;
      r_ipc   <= 32'd0;
      r_fault <= 1'b0;
      r_code  <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fetch <= w_in_txn;
      r_busy  <= w_in_txn;
      r_valid <= (w_nstate == S_HOLD);
      r_fault <= (w_nstate == S_FAULT);
      r_code  <= w_code_nxt;
      if (w_nstate == S_ISSUE) r_addr <= r_pc;
      if (w_cap) begin
        r_iout <= instr;
        r_ipc  <= r_pc;
      end
    end
  end

  assign instrfetch  = r_fetch;
  assign addr_imem   = r_addr;
  assign instr_valid = r_valid;
  assign instr_out   = r_iout;
  assign instr_pc    = r_ipc;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign busy        = r_busy;

endmodule
